rice_core_issue_controller: RTL and testbench

- Sequences the ID->EX handoff of the in-order core.
- Tracks in-flight register writes in an in-order queue and detects RAW hazards against them (no forwarding).
- Drives pipeline stall/flush from branch-taken requests and enable/drain control.
- Sits beside the ID stage; its o_stall/o_flush feed the pipeline interface's stall/flush.

---
 rtl/rice_core_issue_controller_pkg.sv | 21 ++
 rtl/rice_core_issue_queue.sv | 97 +++++++++
 rtl/rice_core_issue_controller.sv | 150 +++++++++++++++
 tb/tb_rice_core_issue_controller.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rice_core_issue_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rice_core_issue_controller_pkg
// Description : Shared types for the ID->EX issue controller: controller
//               state encoding and register-index types.
// Revision    : 1.0 - initial release
// ============================================================================
package rice_core_issue_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } rice_core_issue_state;

    typedef logic [4:0] rice_core_rd;
    typedef logic [4:0] rice_core_rs;

endpackage
`default_nettype wire

// File: rtl/rice_core_issue_queue.sv
`default_nettype none
// ============================================================================
// Module      : rice_core_issue_queue
// Description : In-order FIFO of destination registers for in-flight writes.
//               Provides occupancy count, head entry and a registered mask of
//               all registers with a write outstanding.
// Ports       : i_clk/i_rst_n  clock, async active-low reset
//               i_push/i_push_rd  enqueue a destination register
//               i_pop          dequeue the head entry
//               o_count        number of valid entries (0..DEPTH)
//               o_head         oldest destination register
//               o_mask         bit n set = at least one entry holds xn
// Revision    : 1.0 - initial release
// ============================================================================
import rice_core_issue_controller_pkg::*;

module rice_core_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  rice_core_rd              i_push_rd,
    input  logic                     i_pop,
    output logic [$clog2(DEPTH):0]   o_count,
    output rice_core_rd              o_head,
    output logic [31:0]              o_mask
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    rice_core_rd          rd_q [DEPTH];
    rice_core_rd          rd_d [DEPTH];
    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [31:0]          mask_q, mask_d;

    // Pointers are exactly c_PTR_W bits wide so DEPTH (a power of two) wraps
    // naturally. The caller never pushes into a full queue, so a push slot
    // never collides with the slot being popped.
    always_comb begin
        rd_d     = rd_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (i_push) begin
            rd_d[wr_ptr_q]    = i_push_rd;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (i_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        count_d = count_q + c_CNT_W'(i_push) - c_CNT_W'(i_pop);

        // Mask is built from next-state contents so it is valid the cycle
        // after a push/pop. Duplicates naturally keep the bit set until the
        // last copy leaves.
        mask_d = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_d[i]) begin
                mask_d[rd_d[i]] = 1'b1;
            end
        end
        mask_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mask_q   <= '0;
        end else begin
            rd_q     <= rd_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mask_q   <= mask_d;
        end
    end

    assign o_count = count_q;
    assign o_head  = rd_q[rd_ptr_q];
    assign o_mask  = mask_q;

endmodule
`default_nettype wire

// File: rtl/rice_core_issue_controller.sv
`default_nettype none
// ============================================================================
// Module      : rice_core_issue_controller
// Description : Sequences the ID->EX handoff. Tracks in-flight register
//               writes, stalls on RAW hazards (no forwarding), flushes IF/ID
//               on taken branches and drains on disable.
// Ports       : i_clk, i_rst_n        clock, async active-low reset
//               i_enable              core run enable
//               i_id_valid/rs1/rs2/rd ID-stage instruction
//               i_wb_valid/i_wb_rd    retiring write
//               i_branch_taken        EX redirect
//               o_issue/o_stall/o_flush  pipeline control
//               o_pending_mask        in-flight write mask
//               o_busy                not idle or writes outstanding
//               o_error               sticky writeback-ordering error
// Revision    : 1.0 - initial release
// ============================================================================
import rice_core_issue_controller_pkg::*;

module rice_core_issue_controller #(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_enable,
    input  logic         i_id_valid,
    input  logic [4:0]   i_id_rs1,
    input  logic [4:0]   i_id_rs2,
    input  logic [4:0]   i_id_rd,
    input  logic         i_wb_valid,
    input  logic [4:0]   i_wb_rd,
    input  logic         i_branch_taken,
    output logic         o_issue,
    output logic         o_stall,
    output logic         o_flush,
    output logic [31:0]  o_pending_mask,
    output logic         o_busy,
    output logic         o_error
);

    localparam int c_QCNT_W = $clog2(DEPTH) + 1;
    localparam int c_FCNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES - 1) : 1;

    rice_core_issue_state  state_q, state_d;
    logic [c_FCNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic                  error_q, error_d;

    logic [c_QCNT_W-1:0]   w_count;
    logic [c_QCNT_W-1:0]   w_count_after_pop;
    rice_core_rd           w_head;
    logic [31:0]           w_mask;
    logic                  w_hazard;
    logic                  w_full;
    logic                  w_wb_act;
    logic                  w_pop;
    logic                  w_push;

    rice_core_issue_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_push    (w_push),
        .i_push_rd (i_id_rd),
        .i_pop     (w_pop),
        .o_count   (w_count),
        .o_head    (w_head),
        .o_mask    (w_mask)
    );

    // Hazard and full use the registered (pre-pop) view: ID reads the
    // register file before a same-cycle writeback lands.
    assign w_hazard = ((i_id_rs1 != 5'd0) && w_mask[i_id_rs1]) ||
                      ((i_id_rs2 != 5'd0) && w_mask[i_id_rs2]);
    assign w_full   = (w_count == c_QCNT_W'(DEPTH));

    assign w_wb_act          = i_wb_valid && (i_wb_rd != 5'd0);
    assign w_pop             = w_wb_act && (w_count != '0);
    assign w_count_after_pop = w_count - c_QCNT_W'(w_pop);

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        o_flush     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                o_flush = i_branch_taken;
                if (!i_enable) begin
                    state_d = ST_DRAIN;
                end else if (i_branch_taken && (FLUSH_CYCLES > 1)) begin
                    // Branch cycle itself is the first flush cycle.
                    state_d     = ST_FLUSH;
                    flush_cnt_d = c_FCNT_W'(FLUSH_CYCLES - 2);
                end
            end
            ST_FLUSH: begin
                o_flush = 1'b1;
                if (!i_enable) begin
                    state_d = ST_DRAIN;
                end else if (flush_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (w_count_after_pop == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        o_issue = (state_q == ST_RUN) && i_enable && i_id_valid &&
                  !w_hazard && !w_full && !o_flush;
        o_stall = i_id_valid && !o_issue && !o_flush;
        w_push  = o_issue && (i_id_rd != 5'd0);

        // Mismatched head is still popped; writeback on empty is not.
        error_d = error_q ||
                  (w_wb_act && ((w_count == '0) || (i_wb_rd != w_head)));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            error_q     <= error_d;
        end
    end

    assign o_pending_mask = w_mask;
    assign o_busy         = (state_q != ST_IDLE) || (w_count != '0);
    assign o_error        = error_q;

endmodule
`default_nettype wire

// File: tb/tb_rice_core_issue_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_rice_core_issue_controller
// Description : Randomized self-checking bench for the issue controller with
//               a queue-based reference model of the pipeline rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rice_core_issue_controller;

    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int N_CYCLES     = 3000;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        branch_taken;
    logic        issue, stall, flush, busy, error;
    logic [31:0] pending_mask;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: pipeline mode as flags, in-flight writes as a queue.
    bit   m_running;
    bit   m_draining;
    int   m_flush_left;
    bit   m_error;
    int   m_q[$];

    rice_core_issue_controller #(
        .DEPTH        (DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_enable       (enable),
        .i_id_valid     (id_valid),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_rd        (id_rd),
        .i_wb_valid     (wb_valid),
        .i_wb_rd        (wb_rd),
        .i_branch_taken (branch_taken),
        .o_issue        (issue),
        .o_stall        (stall),
        .o_flush        (flush),
        .o_pending_mask (pending_mask),
        .o_busy         (busy),
        .o_error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_flight(input int r);
        foreach (m_q[i]) begin
            if (m_q[i] == r) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = 32'd0;
        foreach (m_q[i]) m[m_q[i]] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic model_reset();
        m_running    = 1'b0;
        m_draining   = 1'b0;
        m_flush_left = 0;
        m_error      = 1'b0;
        m_q.delete();
    endtask

    task automatic zero_inputs();
        enable       = 1'b0;
        id_valid     = 1'b0;
        id_rs1       = 5'd0;
        id_rs2       = 5'd0;
        id_rd        = 5'd0;
        wb_valid     = 1'b0;
        wb_rd        = 5'd0;
        branch_taken = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_issue"}, {31'd0, issue}, 32'd0);
        check({tag, "_stall"}, {31'd0, stall}, 32'd0);
        check({tag, "_flush"}, {31'd0, flush}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy},  32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_mask"},  pending_mask,   32'd0);
    endtask

    // Compare current outputs with the model, then advance the model with
    // the inputs the DUT will capture on the coming rising edge.
    task automatic step_model();
        bit run_st, flush_st, idle_st;
        bit haz, full, e_flush, e_issue, e_stall, wb_act;
        run_st   = m_running && (m_flush_left == 0);
        flush_st = m_running && (m_flush_left > 0);
        idle_st  = !m_running && !m_draining;

        haz  = ((id_rs1 != 0) && in_flight(int'(id_rs1))) ||
               ((id_rs2 != 0) && in_flight(int'(id_rs2)));
        full = (m_q.size() == DEPTH);
        e_flush = (run_st && branch_taken) || flush_st;
        e_issue = run_st && enable && id_valid && !haz && !full && !e_flush;
        e_stall = id_valid && !e_issue && !e_flush;

        check("issue", {31'd0, issue}, {31'd0, e_issue});
        check("stall", {31'd0, stall}, {31'd0, e_stall});
        check("flush", {31'd0, flush}, {31'd0, e_flush});
        check("busy",  {31'd0, busy},  {31'd0, (!idle_st || m_q.size() != 0)});
        check("error", {31'd0, error}, {31'd0, m_error});
        check("mask",  pending_mask,   model_mask());

        wb_act = wb_valid && (wb_rd != 0);
        if (wb_act) begin
            if (m_q.size() == 0) begin
                m_error = 1'b1;
            end else begin
                if (m_q[0] != int'(wb_rd)) m_error = 1'b1;
                void'(m_q.pop_front());
            end
        end
        if (e_issue && id_rd != 0) m_q.push_back(int'(id_rd));

        if (idle_st) begin
            if (enable) m_running = 1'b1;
        end else if (run_st) begin
            if (!enable) begin
                m_running  = 1'b0;
                m_draining = 1'b1;
            end else if (branch_taken && FLUSH_CYCLES > 1) begin
                m_flush_left = FLUSH_CYCLES - 1;
            end
        end else if (flush_st) begin
            if (!enable) begin
                m_running    = 1'b0;
                m_draining   = 1'b1;
                m_flush_left = 0;
            end else begin
                m_flush_left--;
            end
        end else begin
            if (m_q.size() == 0) m_draining = 1'b0;
        end
    endtask

    initial begin
        zero_inputs();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc % 500 == 250) begin
                // Asynchronous reset in the middle of traffic.
                zero_inputs();
                rst_n = 1'b0;
                #1;
                check_all_zero("async_rst");
                model_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                enable       = ($urandom_range(0, 19) != 0);
                id_valid     = ($urandom_range(0, 3) != 0);
                id_rs1       = 5'($urandom_range(0, 7));
                id_rs2       = 5'($urandom_range(0, 7));
                id_rd        = 5'($urandom_range(0, 7));
                branch_taken = ($urandom_range(0, 11) == 0);
                wb_valid     = ($urandom_range(0, 2) == 0);
                if (m_q.size() != 0 && $urandom_range(0, 15) != 0)
                    wb_rd = 5'(m_q[0]);
                else
                    wb_rd = 5'($urandom_range(0, 7));
                @(negedge clk);
                step_model();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
